// File: rtl/didactic_uart_rx.sv
// didactic_uart_rx: 8N1/8E1 UART receive monitor reporting each byte with a one-cycle strobe and error flags
module didactic_uart_rx #(
  parameter int CLK_FREQ  = 8_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY_EN = 0
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_en,
  output logic [7:0] data,
  output logic       word_done,
  output logic       parity_error,
  output logic       frame_error
);
  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_rate
    $error("didactic_uart_rx: CLKS_PER_BIT must be at least 4");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rx_s, rx_prev_q, tick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  logic          par_q, par_d, done_q, done_d, perr_q, perr_d, ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      done_q    <= done_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  // The start bit is sampled half a bit in so every later sample lands mid-bit.
  assign tick = cnt_q == ((state_q == START) ? HALF_M1 : FULL_M1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (rx_prev_q && !rx_s && rx_en) state_d = START;
      START:     if (tick) state_d = rx_s ? IDLE : DATA;
      DATA:      if (tick && idx_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:    if (tick) state_d = STOP;
      STOP:      if (tick) state_d = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = (state_q == IDLE || state_q == WAIT_IDLE || tick) ? '0 : cnt_q + 1'b1;
    idx_d   = (state_q != DATA) ? 3'd0 : tick ? idx_q + 3'd1 : idx_q;
    shift_d = (state_q == DATA && tick) ? {rx_s, shift_q[7:1]} : shift_q;
    par_d   = (state_q == PARITY && tick) ? rx_s : par_q;
    done_d  = state_q == STOP && tick;
    data_d  = done_d ? shift_q : data_q;
    perr_d  = done_d ? (PARITY_EN != 0) && ((^shift_q) != par_q) : perr_q;
    ferr_d  = done_d ? !rx_s : ferr_q;
  end

  always_comb begin
    data         = data_q;
    word_done    = done_q;
    parity_error = perr_q;
    frame_error  = ferr_q;
  end
endmodule

// File: tb/tb_didactic_uart_rx.sv
// tb_didactic_uart_rx: drives 8N1 and 8E1 receivers with directed and random frames against a frame-level model
module tb_didactic_uart_rx;
  localparam int N = 69;
  localparam int H = 34;

  typedef struct {logic [7:0] d; logic p; logic f; int c;} exp_t;

  logic       clk = 1'b0;
  logic [1:0] rst_l = 2'b11;
  logic [1:0] rx_l = 2'b11;
  logic [1:0] en_l = 2'b11;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %0h expected %0h", i, nm, act, exp_v);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    logic [7:0] data;
    logic       wd, pe, fe;
    exp_t       q[$];
    exp_t       e;
    logic [7:0] cur_d = 8'h00;
    logic       cur_p = 1'b0;
    logic       cur_f = 1'b0;
    int         last_strobe = 0;

    didactic_uart_rx #(.PARITY_EN(g)) u (
      .clk_in(clk), .reset(rst_l[g]), .rx(rx_l[g]), .rx_en(en_l[g]),
      .data(data), .word_done(wd), .parity_error(pe), .frame_error(fe)
    );

    always @(negedge clk) begin
      if (wd) begin
        last_strobe = cyc;
        if (q.size() == 0) chk(g, "unexpected word_done", 1, 0);
        else begin
          e = q.pop_front();
          chk(g, "word_done cycle", cyc, e.c);
          cur_d = e.d;
          cur_p = e.p;
          cur_f = e.f;
        end
      end
      chk(g, "data", data, cur_d);
      chk(g, "parity_error", pe, cur_p);
      chk(g, "frame_error", fe, cur_f);
    end
  end

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Frame-level model: strobe lands 2 sync cycles + H + (9+P)*N + 1 after the pin falls.
  task automatic send(input int i, input logic [7:0] b, input logic pb, input logic sb, input int bl, input bit expect_it);
    exp_t e;
    logic [10:0] fr;
    int nb;
    nb = (i == 1) ? 11 : 10;
    fr = (i == 1) ? {sb, pb, b, 1'b0} : {1'b0, sb, b, 1'b0};
    e.d = b;
    e.p = (i == 1) ? ((^b) != pb) : 1'b0;
    e.f = ~sb;
    e.c = cyc + 3 + H + (nb - 1) * N;
    if (expect_it) begin
      if (i == 0) inst[0].q.push_back(e);
      else inst[1].q.push_back(e);
    end
    for (int j = 0; j < nb; j++) begin
      rx_l[i] = fr[j];
      idle(bl);
    end
  endtask

  initial begin
    int f;
    logic [7:0] b;
    int i;
    idle(3);
    rst_l = 2'b00;
    chk(0, "reset data", inst[0].data, 8'h00);
    chk(0, "reset word_done", inst[0].wd, 0);
    chk(1, "reset parity_error", inst[1].pe, 0);
    chk(1, "reset frame_error", inst[1].fe, 0);
    idle(20);

    f = cyc;
    send(0, 8'h55, 1'b0, 1'b1, N, 1);
    chk(0, "0x55 latency", inst[0].last_strobe - f, 658);
    chk(0, "0x55 data", inst[0].data, 8'h55);
    chk(0, "0x55 flags", {inst[0].pe, inst[0].fe}, 2'b00);
    idle(10);

    send(0, 8'h00, 1'b0, 1'b1, N, 1);
    send(0, 8'hFF, 1'b0, 1'b1, N, 1);
    send(0, 8'hA3, 1'b0, 1'b1, N, 1);
    idle(10);
    chk(0, "back-to-back last data", inst[0].data, 8'hA3);

    f = cyc;
    send(1, 8'hA3, 1'b0, 1'b1, N, 1);
    chk(1, "parity latency", inst[1].last_strobe - f, 727);
    chk(1, "0xA3 good parity", inst[1].pe, 0);
    send(1, 8'hA3, 1'b1, 1'b1, N, 1);
    chk(1, "0xA3 bad parity", inst[1].pe, 1);
    idle(10);

    send(0, 8'h3C, 1'b0, 1'b0, N, 1);
    idle(160);
    rx_l[0] = 1'b1;
    idle(30);
    chk(0, "0x3C frame_error", inst[0].fe, 1);
    send(0, 8'h12, 1'b0, 1'b1, N, 1);
    idle(10);
    chk(0, "0x12 frame_error", inst[0].fe, 0);

    rx_l[0] = 1'b0;
    idle(10);
    rx_l[0] = 1'b1;
    idle(200);

    en_l[0] = 1'b0;
    send(0, 8'h99, 1'b0, 1'b1, N, 0);
    idle(5);
    en_l[0] = 1'b1;
    idle(20);

    fork
      send(0, 8'h5A, 1'b0, 1'b1, N, 1);
      begin
        idle(3 * N);
        en_l[0] = 1'b0;
      end
    join
    en_l[0] = 1'b1;
    idle(10);

    send(0, 8'hC6, 1'b0, 1'b1, 67, 1);
    send(0, 8'h39, 1'b0, 1'b1, 71, 1);
    send(1, 8'h6D, 1'b1, 1'b1, 67, 1);
    send(1, 8'h81, 1'b1, 1'b1, 71, 1);
    idle(20);

    b = 8'hA5;
    rx_l[0] = 1'b0;
    idle(N);
    for (int j = 0; j < 4; j++) begin
      rx_l[0] = b[j];
      idle(N);
    end
    rx_l[0] = b[4];
    idle(N / 2);
    rst_l[0] = 1'b1;
    inst[0].cur_d = 8'h00;
    inst[0].cur_p = 1'b0;
    inst[0].cur_f = 1'b0;
    rx_l[0] = 1'b1;
    idle(4);
    chk(0, "mid-frame reset data", inst[0].data, 8'h00);
    rst_l[0] = 1'b0;
    idle(50);
    send(0, 8'h7E, 1'b0, 1'b1, N, 1);
    idle(10);
    chk(0, "0x7E after reset", inst[0].data, 8'h7E);

    for (int k = 0; k < 16; k++) begin
      i = int'($urandom_range(0, 1));
      send(i, 8'($urandom), 1'($urandom), 1'b1, int'($urandom_range(67, 71)), 1);
      idle(int'($urandom_range(0, 2)) * N);
    end

    for (int k = 0; k < 3000 && (inst[0].q.size() + inst[1].q.size()) != 0; k++) idle(1);
    chk(0, "frames left undelivered", inst[0].q.size() + inst[1].q.size(), 0);
    idle(100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/didactic_uart_rx.md
# didactic_uart_rx

Synthesizable UART receive monitor for the Didactic SoC. It watches the SoC `uart_tx` pin, deserialises 8N1 (optionally 8E1) frames, and reports each byte with a single-cycle strobe plus error flags. It runs on the SoC board clock (8 MHz nominal) and supports observation of SoC console output in simulation and on FPGA.

## Interface
Parameters:
- `CLK_FREQ`, 8_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in baud.
- `PARITY_EN`, 0: 1 means a parity bit follows the data bits; the parity scheme is even.
- Derived `CLKS_PER_BIT` = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE, which is 69 at the defaults. It must be ≥ 4; otherwise the build fails by elaboration assertion.

Ports:
- `clk_in`, in, 1: the single clock. Everything is rising-edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `rx`, in, 1: serial line, idle high, asynchronous to `clk_in`.
- `rx_en`, in, 1: enables detection of a new start bit.
- `data`, out, 8: last received byte, LSB received first.
- `word_done`, out, 1: one-cycle strobe when a frame completes.
- `parity_error`, out, 1: parity check result of the last frame.
- `frame_error`, out, 1: stop bit of the last frame sampled low.

## Operation
- `rx` passes through a 2-flop synchroniser, giving `rx_s`. The synchroniser resets to 1. All logic below uses `rx_s`.
- The FSM has states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE. A bit counter (`CLKS_PER_BIT` range) and a 3-bit index are used.
- **IDLE:** a falling edge of `rx_s` (previous 1, current 0) while `rx_en` = 1 moves to START and clears the bit counter.
- **START:** wait `CLKS_PER_BIT/2` cycles (integer division), then sample.
  - Sample 0: go to DATA.
  - Sample 1: false start, return to IDLE with no strobe and no flag changes.
- **DATA:** every `CLKS_PER_BIT` cycles, sample one bit into a shift register, LSB first, 8 bits. Then go to PARITY if `PARITY_EN`, else STOP.
- **PARITY:** sample after `CLKS_PER_BIT` cycles. The error condition is (XOR of 8 data bits) ≠ sampled bit.
- **STOP:** sample after `CLKS_PER_BIT` cycles. On the next cycle:
  - `data` ← shift register.
  - `parity_error` ← computed value, forced 0 when `PARITY_EN` = 0.
  - `frame_error` ← (stop sample == 0).
  - `word_done` = 1 for one cycle.
  - Next state: IDLE if the stop sample is 1, else WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s` = 1, then go to IDLE. This prevents a break condition from being read as a new start.
- `rx_en` only gates start detection. A frame already in progress completes even if `rx_en` falls.
- `data`, `parity_error` and `frame_error` hold their values until the next completed frame. Errors still produce `word_done`.

## Timing
- Reset values: `data` = 0x00, `word_done` = 0, `parity_error` = 0, `frame_error` = 0, FSM in IDLE, synchroniser = 1.
- Reset asserted mid-frame aborts the frame immediately with no strobe. After release, the block waits for a fresh falling edge.
- Latency uses cycle 0 as the first cycle in which `rx_s` = 0 (2 cycles after the pin falls). Let H = `CLKS_PER_BIT/2` and N = `CLKS_PER_BIT`.
  - Start sample: cycle H.
  - Data bit i: cycle H + (i+1)·N.
  - Parity: cycle H + 9N.
  - Stop: cycle H + (9+P)·N, where P = `PARITY_EN`.
  - `word_done` is high in cycle H + (9+P)·N + 1.
- Back-to-back frames, with a start bit immediately after the stop bit, must be received. The FSM is in IDLE again about H cycles before the next start edge.
- Tolerance: any rate error within ±3 % must be received correctly.

## Test plan
- Defaults. Drive 0x55 at 115200 baud (8.68 µs/bit) → one `word_done` pulse; `data` = 0x55; both error flags 0.
- Defaults. Send 0x00, 0xFF, 0xA3 back-to-back with no idle gap → exactly three pulses, in order, with matching `data`.
- `PARITY_EN` = 1.
  - Send 0xA3 with parity bit 0 → `parity_error` = 0.
  - Send 0xA3 with parity bit 1 → `parity_error` = 1.
- Send 0x3C with the stop bit driven 0 and the line held low 20 µs → `word_done`, `frame_error` = 1, no second frame detected. The next valid 0x12 is received with `frame_error` = 0.
- Low glitch of 10 cycles on `rx` → no `word_done`, outputs unchanged.
- Two negative cases:
  - `rx_en` = 0 during a frame start → frame ignored.
  - `reset` pulsed in the middle of data bit 4 → no strobe, outputs at reset values; the following frame 0x7E is received correctly.
